// File: rtl/msg_arb_pkg.sv
// ---------------------------------------------------------------------------
// msg_arb_pkg
// Shared definitions for the message arbiter and its helpers:
//   - FSM state encoding (IDLE, SEND, WAIT, GAP)
//   - default message width of the frame serializer payload
//   - serializer frame header constant
//   - timer_width(): width of a down-counter covering the frame and gap loads
// ---------------------------------------------------------------------------
package msg_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  localparam int MSG_W_DEF = 32'sd5;

  // Header the serializer prepends to every 5-bit message.
  localparam logic [3:0] FRAME_HEADER = 4'b0101;

  // Bits needed to hold max(frame_cycles, gap_cycles) without wrapping.
  function automatic int timer_width(input int frame_cycles, input int gap_cycles);
    int m;
    m = (frame_cycles > gap_cycles) ? frame_cycles : gap_cycles;
    return $clog2(m + 32'sd1);
  endfunction

endpackage

// File: rtl/message_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin picker. Searches req upward starting at ptr+1
// (mod N_REQ) and reports the first set index.
// Ports:
//   req  in  N_REQ  request vector
//   ptr  in  PTR_W  index of the most recently served requester
//   win  out PTR_W  selected requester (0 when no request is pending)
//   any  out 1      at least one request is pending
// ---------------------------------------------------------------------------
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] win,
  output logic             any
);

  // Scan from the farthest offset down to ptr+1 so the nearest hit wins last.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int off = N_REQ; off != 32'sd0; off--) begin
      int pos;
      pos = (int'(ptr) + off) % N_REQ;
      win = req[pos[PTR_W-1:0]] ? pos[PTR_W-1:0] : win;
      any = any | req[pos[PTR_W-1:0]];
    end
  end

endmodule

// File: rtl/message_arbiter.sv
// ---------------------------------------------------------------------------
// message_arbiter
// Round-robin arbiter/sequencer sharing one frame serializer among N_REQ
// requesters. Picks a pending requester, latches its message, pulses send,
// times the frame (FRAME_CYCLES) and the idle gap (GAP_CYCLES), and pulses
// ack to the winner on the last frame cycle.
// Ports:
//   clk      in  1            rising-edge clock
//   rst      in  1            asynchronous active-high reset
//   req      in  N_REQ        request levels, held until ack
//   msg_in   in  N_REQ*MSG_W  requester i message at [i*MSG_W +: MSG_W]
//   send     out 1            one-cycle serializer start
//   message  out MSG_W        latched message of the current owner
//   grant    out N_REQ        one-hot owner during SEND/WAIT
//   ack      out N_REQ        one-hot frame-complete pulse
//   busy     out 1            high whenever not IDLE
// ---------------------------------------------------------------------------
module message_arbiter
  import msg_arb_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int MSG_W        = MSG_W_DEF,
  parameter int FRAME_CYCLES = 9216,
  parameter int GAP_CYCLES   = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*MSG_W-1:0]   msg_in,
  output logic                     send,
  output logic [MSG_W-1:0]         message,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0]         ack,
  output logic                     busy
);

  localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TIMER_W = timer_width(FRAME_CYCLES, GAP_CYCLES);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  localparam logic [TIMER_W-1:0] FRAME_LOAD = TIMER_W'(FRAME_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD   = HAS_GAP ? TIMER_W'(GAP_CYCLES - 1) : '0;
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1'b1);
  // Pointer starts at the last requester so requester 0 wins the first tie.
  localparam logic [PTR_W-1:0]   PTR_RESET  = PTR_W'(N_REQ - 1);

  logic [1:0]         state_q,   state_d;
  logic [PTR_W-1:0]   ptr_q,     ptr_d;
  logic [PTR_W-1:0]   win_q,     win_d;
  logic [TIMER_W-1:0] timer_q,   timer_d;
  logic [MSG_W-1:0]   message_q, message_d;

  logic [PTR_W-1:0]   pick_win;
  logic               pick_any;
  logic [MSG_W-1:0]   sel_msg;
  logic               frame_done;

  rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req (req),
    .ptr (ptr_q),
    .win (pick_win),
    .any (pick_any)
  );

  // Select the message slice belonging to the picker's candidate.
  always_comb begin
    sel_msg = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_msg = (pick_win == PTR_W'(i)) ? msg_in[i*MSG_W +: MSG_W] : sel_msg;
    end
  end

  assign frame_done = (state_q == ST_WAIT) && (timer_q == '0);

  // Next-state, timer, pointer and message latch logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    timer_d   = timer_q;
    message_d = message_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          win_d     = pick_win;
          message_d = sel_msg;
          state_d   = ST_SEND;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SEND: begin
        timer_d = FRAME_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (timer_q == '0) begin
          // Pointer advances only once the frame actually completed.
          ptr_d = win_q;
          if (HAS_GAP) begin
            timer_d = GAP_LOAD;
            state_d = ST_GAP;
          end else begin
            timer_d = '0;
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      ST_GAP: begin
        if (timer_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // State registers with asynchronous reset; an in-flight frame is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= PTR_RESET;
      win_q     <= '0;
      timer_q   <= '0;
      message_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      timer_q   <= timer_d;
      message_q <= message_d;
    end
  end

  // One-hot grant/ack decode from the registered owner index.
  always_comb begin
    grant = '0;
    ack   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant[i] = ((state_q == ST_SEND) || (state_q == ST_WAIT)) && (win_q == PTR_W'(i));
      ack[i]   = frame_done && (win_q == PTR_W'(i));
    end
  end

  assign send    = (state_q == ST_SEND);
  assign busy    = (state_q != ST_IDLE);
  assign message = message_q;

endmodule

// File: tb/tb_message_arbiter.sv
module tb_message_arbiter;

  localparam int N  = 4;
  localparam int MW = 5;
  localparam int F  = 20;
  localparam int G  = 3;
  localparam int F0 = 6;
  localparam int P  = 2 + F + G;   // send-to-send spacing under continuous load
  localparam int NV = 10;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req,  req0;
  logic [N*MW-1:0] msg_in, msg0;
  logic            send, send0;
  logic [MW-1:0]   message, message0;
  logic [N-1:0]    grant, grant0, ack, ack0;
  logic            busy, busy0;

  message_arbiter #(.N_REQ(N), .MSG_W(MW), .FRAME_CYCLES(F), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .req(req), .msg_in(msg_in), .send(send),
    .message(message), .grant(grant), .ack(ack), .busy(busy)
  );

  message_arbiter #(.N_REQ(N), .MSG_W(MW), .FRAME_CYCLES(F0), .GAP_CYCLES(0)) dut_nogap (
    .clk(clk), .rst(rst), .req(req0), .msg_in(msg0), .send(send0),
    .message(message0), .grant(grant0), .ack(ack0), .busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [N-1:0]  oh;
    logic [MW-1:0] msg;
    int            scyc;
    int            acyc;
  } exp_t;

  exp_t send_q[$];
  exp_t ack_q[$];

  typedef struct {
    logic [N-1:0]  req;
    int            win;
    logic [MW-1:0] msg;
    int            drop;
  } vec_t;

  vec_t tbl[NV];

  // Scoreboard: send and ack pulses pop the expectations pushed by stimulus.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      if (send === 1'b1) begin
        if (send_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_send: got grant %b expected no send", grant);
        end else begin
          e = send_q.pop_front();
          chk("send_grant", 32'(grant), 32'(e.oh));
          chk("send_msg",   32'(message), 32'(e.msg));
          chk("send_cycle", 32'(cyc), 32'(e.scyc));
          ack_q.push_back(e);
        end
      end
      if (ack !== 4'b0000) begin
        if (ack_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: got %b expected none", ack);
        end else begin
          e = ack_q.pop_front();
          chk("ack_value", 32'(ack), 32'(e.oh));
          chk("ack_cycle", 32'(cyc), 32'(e.acyc));
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    send_q.delete();
    ack_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Caller is positioned just after a rising edge with the DUT in IDLE.
  task automatic run_entry(input logic [N-1:0] r, input int w, input logic [MW-1:0] m,
                           input int drop, input string tag);
    int   c0;
    int   n;
    exp_t e;
    logic stable;
    c0 = cyc;
    for (int i = 0; i < N; i++) msg_in[i*MW +: MW] = (i == w) ? m : MW'($urandom);
    req    = r;
    e.oh   = 4'b0001 << w;
    e.msg  = m;
    e.scyc = c0 + 1;
    e.acyc = c0 + 1 + F;
    send_q.push_back(e);
    stable = 1'b1;
    n = 0;
    while (ack === 4'b0000 && n < F + 10) begin
      @(posedge clk); #1;
      n++;
      if (drop >= 0 && cyc - c0 == drop) req = 4'b0000;
      if (busy === 1'b1 && message !== m) stable = 1'b0;
    end
    if (ack === 4'b0000) begin
      total++;
      bad++;
      $display("FAIL %s_ack_timeout: got no ack expected ack by cycle %0d", tag, c0 + 1 + F);
    end
    @(posedge clk); #1;
    req = 4'b0000;
    n = 0;
    while (busy === 1'b1 && n < G + 10) begin
      if (message !== m) stable = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_idle_cycle"}, 32'(cyc), 32'(c0 + 2 + F + G));
    chk({tag, "_msg_stable"}, 32'(stable), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "time limit");
  end

  initial begin
    int   c0, n, s1, s2, a1;
    logic [N-1:0]  g1, g2;
    logic [MW-1:0] m1, m2;
    exp_t e;

    rst = 1'b1; req = '0; msg_in = '0; req0 = '0; msg0 = '0;

    // ptr after reset = 3; each line lists the expected round-robin winner.
    tbl[0] = '{req: 4'b0001, win: 0, msg: 5'b10110, drop: -1};
    tbl[1] = '{req: 4'b0001, win: 0, msg: 5'b01011, drop: 10};
    tbl[2] = '{req: 4'b1111, win: 1, msg: 5'b11100, drop: -1};
    tbl[3] = '{req: 4'b1010, win: 3, msg: 5'b00011, drop: -1};
    tbl[4] = '{req: 4'b1010, win: 1, msg: 5'b10101, drop: -1};
    tbl[5] = '{req: 4'b0100, win: 2, msg: 5'b01110, drop: -1};
    tbl[6] = '{req: 4'b1001, win: 3, msg: 5'b11111, drop: -1};
    tbl[7] = '{req: 4'b1001, win: 0, msg: 5'b00001, drop: -1};
    tbl[8] = '{req: 4'b0110, win: 1, msg: 5'b10000, drop: -1};
    tbl[9] = '{req: 4'b0001, win: 0, msg: 5'b01101, drop: -1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_send",    32'(send), 32'd0);
    chk("rst_grant",   32'(grant), 32'd0);
    chk("rst_ack",     32'(ack), 32'd0);
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_message", 32'(message), 32'd0);
    chk("rst_busy_nogap", 32'(busy0), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      run_entry(tbl[i].req, tbl[i].win, tbl[i].msg, tbl[i].drop, $sformatf("vec%0d", i));
    end

    // Pointer was 0 here; after reset it must be 3 again, so 0101 goes to 0.
    do_reset();
    run_entry(4'b0101, 0, 5'b11010, -1, "ptr_reset");

    // Continuous requests from all four rotate 0,1,2,3,0.
    do_reset();
    c0 = cyc;
    msg_in = 20'($urandom);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      e.oh   = 4'b0001 << (k % N);
      e.msg  = msg_in[(k % N)*MW +: MW];
      e.scyc = c0 + 1 + k * P;
      e.acyc = e.scyc + F;
      send_q.push_back(e);
    end
    n = 0;
    while (cyc < c0 + 4 * P + F + 2 && n < 5 * P + 10) begin
      @(posedge clk); #1;
      n++;
    end
    req = 4'b0000;
    n = 0;
    while (busy === 1'b1 && n < G + 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rot_drained", 32'(send_q.size() + ack_q.size()), 32'd0);
    chk("rot_idle", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of WAIT.
    c0 = cyc;
    msg_in[0 +: MW] = 5'b11001;
    req = 4'b0001;
    e.oh = 4'b0001; e.msg = 5'b11001; e.scyc = c0 + 1; e.acyc = c0 + 1 + F;
    send_q.push_back(e);
    n = 0;
    while (cyc < c0 + 12 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("midwait_busy_before", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    send_q.delete();
    ack_q.delete();
    #1;
    chk("arst_send",    32'(send), 32'd0);
    chk("arst_grant",   32'(grant), 32'd0);
    chk("arst_ack",     32'(ack), 32'd0);
    chk("arst_busy",    32'(busy), 32'd0);
    chk("arst_message", 32'(message), 32'd0);
    req = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b0;
    run_entry(4'b0100, 2, 5'b00110, -1, "post_rst");

    // Zero-gap instance: second send follows the first ack by two cycles.
    msg0 = '0;
    msg0[0 +: MW]  = 5'b00111;
    msg0[MW +: MW] = 5'b11000;
    req0 = 4'b0011;
    c0 = cyc;
    s1 = -1; s2 = -1; a1 = -1;
    g1 = '0; g2 = '0; m1 = '0; m2 = '0;
    n = 0;
    while (s2 < 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (send0 === 1'b1) begin
        if (s1 < 0) begin
          s1 = cyc; g1 = grant0; m1 = message0;
        end else begin
          s2 = cyc; g2 = grant0; m2 = message0;
        end
      end
      if (ack0 !== 4'b0000 && a1 < 0) a1 = cyc;
    end
    req0 = 4'b0000;
    n = 0;
    while (busy0 === 1'b1 && n < F0 + 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("gap0_send1_cycle", 32'(s1), 32'(c0 + 1));
    chk("gap0_grant1",      32'(g1), 32'b0001);
    chk("gap0_msg1",        32'(m1), 32'b00111);
    chk("gap0_ack_cycle",   32'(a1), 32'(c0 + 1 + F0));
    chk("gap0_send2_cycle", 32'(s2), 32'(a1 + 2));
    chk("gap0_grant2",      32'(g2), 32'b0010);
    chk("gap0_msg2",        32'(m2), 32'b11000);
    chk("gap0_idle",        32'(busy0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
